b3_serial_decrementer: RTL and testbench



---
 rtl/b3_serial_decrementer_pkg.sv | 22 ++
 rtl/b3_serial_decrementer_halfsubtractor.sv | 33 +++
 rtl/b3_serial_decrementer.sv | 127 ++++++++++++
 tb/tb_b3_serial_decrementer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/b3_serial_decrementer_pkg.sv
// +----------------------------------------------------------------------+
// | b3_serial_decrementer_pkg                                            |
// | Base-3 digit codes and FSM state encodings for the serial decrementer|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package b3_serial_decrementer_pkg;

  localparam logic [1:0] B3_D0  = 2'b00;
  localparam logic [1:0] B3_D1  = 2'b01;
  localparam logic [1:0] B3_D2  = 2'b10;
  localparam logic [1:0] B3_ILL = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RIPPLE = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/b3_serial_decrementer_halfsubtractor.sv
// +----------------------------------------------------------------------+
// | b3_halfsubtractor                                                    |
// | Combinational base-3 half subtractor: d = (x - bin) mod 3            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module b3_halfsubtractor
  import b3_serial_decrementer_pkg::*;
(
  input  logic [1:0] x1_x0,
  input  logic       bin,
  output logic [1:0] d1_d0,
  output logic       bout
);

  always_comb begin
    d1_d0 = x1_x0;
    if (bin) begin
      case (x1_x0)
        B3_D0:   d1_d0 = B3_D2;
        B3_D1:   d1_d0 = B3_D0;
        B3_D2:   d1_d0 = B3_D1;
        default: d1_d0 = B3_D0;  // illegal digit, result is don't-care
      endcase
    end
  end

  assign bout = bin & (x1_x0 == B3_D0);

endmodule

`default_nettype wire

// File: rtl/b3_serial_decrementer.sv
// +----------------------------------------------------------------------+
// | b3_serial_decrementer                                                |
// | N-digit base-3 register, decremented one digit per clock, LSD first. |
// | Optional: B3_SATURATE_EN makes decrement of zero saturate at zero.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module b3_serial_decrementer
  import b3_serial_decrementer_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_,
  input  logic                  load,
  input  logic [2*N_DIGITS-1:0] din,
  input  logic                  dec,
  output logic [2*N_DIGITS-1:0] q,
  output logic                  busy,
  output logic                  done,
  output logic                  uflow,
  output logic                  zero,
  output logic                  lerr
);

  localparam int c_IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_DIGITS - 1);

  state_t                r_state;
  logic [2*N_DIGITS-1:0] r_q;
  logic [c_IDX_W-1:0]    r_idx;
  logic                  r_borrow;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_uflow;
  logic                  r_lerr;

  logic [1:0]            w_sel_digit;
  logic [1:0]            w_diff;
  logic                  w_bout;
  logic                  w_din_legal;

  assign w_sel_digit = r_q[{r_idx, 1'b0} +: 2];

  b3_halfsubtractor u_halfsub (
    .x1_x0 (w_sel_digit),
    .bin   (r_borrow),
    .d1_d0 (w_diff),
    .bout  (w_bout)
  );

  always_comb begin
    w_din_legal = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (din[2*i +: 2] == B3_ILL) w_din_legal = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state  <= ST_IDLE;
      r_q      <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_uflow  <= 1'b0;
      r_lerr   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_uflow <= 1'b0;
      r_lerr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            if (w_din_legal) r_q    <= din;
            else             r_lerr <= 1'b1;
          end else if (dec) begin
`ifdef B3_SATURATE_EN
            if (r_q == '0) begin
              r_done  <= 1'b1;
              r_uflow <= 1'b1;
            end else begin
              r_state  <= ST_RIPPLE;
              r_idx    <= '0;
              r_borrow <= 1'b1;
              r_busy   <= 1'b1;
            end
`else
            r_state  <= ST_RIPPLE;
            r_idx    <= '0;
            r_borrow <= 1'b1;
            r_busy   <= 1'b1;
`endif
          end
        end
        ST_RIPPLE: begin
          r_q[{r_idx, 1'b0} +: 2] <= w_diff;
          // Stop once the borrow is absorbed or the MSD has been processed
          if (!w_bout || (r_idx == c_LAST_IDX)) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_uflow  <= w_bout;
          end else begin
            r_idx    <= r_idx + 1'b1;
            r_borrow <= w_bout;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign q     = r_q;
  assign busy  = r_busy;
  assign done  = r_done;
  assign uflow = r_uflow;
  assign lerr  = r_lerr;
  assign zero  = (r_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_b3_serial_decrementer.sv
// +----------------------------------------------------------------------+
// | tb_b3_serial_decrementer                                             |
// | Directed self-checking bench for b3_serial_decrementer (N_DIGITS=4). |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_b3_serial_decrementer;

  localparam int N_DIGITS = 4;

  logic                  clock;
  logic                  reset_;
  logic                  load;
  logic [2*N_DIGITS-1:0] din;
  logic                  dec;
  logic [2*N_DIGITS-1:0] q;
  logic                  busy;
  logic                  done;
  logic                  uflow;
  logic                  zero;
  logic                  lerr;

  int n_vec;
  int n_err;

  b3_serial_decrementer #(.N_DIGITS(N_DIGITS)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .load   (load),
    .din    (din),
    .dec    (dec),
    .q      (q),
    .busy   (busy),
    .done   (done),
    .uflow  (uflow),
    .zero   (zero),
    .lerr   (lerr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Base-3 integer to 2-bit-per-digit code
  function automatic logic [7:0] enc(input int v);
    logic [7:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[2*i +: 2] = 2'(t % 3);
      t = t / 3;
    end
    return r;
  endfunction

  function automatic int ripple_edges(input int v);
    int t;
    int n;
    t = v;
    n = 1;
    for (int i = 0; i < 3; i++) begin
      if (t % 3 != 0) break;
      n++;
      t = t / 3;
    end
    return n;
  endfunction

  task automatic load_val(input logic [7:0] v);
    load = 1'b1;
    din  = v;
    tick();
    load = 1'b0;
  endtask

  // Issue one decrement of a stored value old_v and check the full outcome
  task automatic do_dec(input string tag, input int old_v, input bit hold);
    int new_v;
    int exp_n;
    int n;
`ifdef B3_SATURATE_EN
    new_v = (old_v == 0) ? 0 : old_v - 1;
    exp_n = (old_v == 0) ? 0 : ripple_edges(old_v);
`else
    new_v = (old_v == 0) ? 80 : old_v - 1;
    exp_n = ripple_edges(old_v);
`endif
    dec = 1'b1;
    tick();
    if (!hold) dec = 1'b0;
    n = 0;
    while (busy && n < 8) begin
      tick();
      n++;
    end
    dec = 1'b0;
    check_eq({tag, ".edges"}, n, exp_n);
    check_eq({tag, ".done"}, done, 1'b1);
    check_eq({tag, ".uflow"}, uflow, (old_v == 0));
    check_eq({tag, ".q"}, q, enc(new_v));
    check_eq({tag, ".zero"}, zero, (new_v == 0));
    tick();
    check_eq({tag, ".done_clr"}, done, 1'b0);
    check_eq({tag, ".busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset_ = 1'b0;
    load   = 1'b0;
    dec    = 1'b0;
    din    = '0;
    tick();
    tick();
    check_eq("rst.q", q, 8'h00);
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.done", done, 1'b0);
    check_eq("rst.uflow", uflow, 1'b0);
    check_eq("rst.lerr", lerr, 1'b0);
    check_eq("rst.zero", zero, 1'b1);
    @(negedge clock);
    reset_ = 1'b1;

    // Reset in the middle of a ripple
    load_val(8'b01_00_00_00);
    dec = 1'b1;
    tick();
    dec = 1'b0;
    check_eq("midrst.busy_pre", busy, 1'b1);
    tick();
    check_eq("midrst.q_partial", q, 8'b01_00_00_10);
    reset_ = 1'b0;
    #1;
    check_eq("midrst.q", q, 8'h00);
    check_eq("midrst.busy", busy, 1'b0);
    @(negedge clock);
    reset_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("midrst.no_done", done, 1'b0);
    end

    // Fast path, ripple with dec held while busy, underflow
    load_val(8'b00_00_01_10);
    do_dec("fast", 5, 1'b0);
    load_val(8'b00_01_00_00);
    do_dec("ripple", 9, 1'b1);
    check_eq("ripple.q_after_drop", q, 8'b00_00_10_10);
    load_val(8'b00_00_00_00);
    do_dec("uflow", 0, 1'b0);

    // Illegal load rejected, q unchanged
    load_val(8'b00_00_01_10);
    load_val(8'b00_11_00_01);
    check_eq("lerr.pulse", lerr, 1'b1);
    check_eq("lerr.q", q, 8'b00_00_01_10);
    tick();
    check_eq("lerr.clear", lerr, 1'b0);

    // load has priority over dec
    load = 1'b1;
    dec  = 1'b1;
    din  = 8'b00_00_00_10;
    tick();
    load = 1'b0;
    dec  = 1'b0;
    check_eq("prio.q", q, 8'b00_00_00_10);
    check_eq("prio.busy", busy, 1'b0);
    tick();
    check_eq("prio.busy2", busy, 1'b0);
    check_eq("prio.done", done, 1'b0);

    // Full sweep from 2222 down through 0000 and one step past it
    load_val(8'b10_10_10_10);
    check_eq("sweep.start", q, 8'b10_10_10_10);
    for (int v = 80; v >= 0; v--) begin
      do_dec($sformatf("sweep%0d", v), v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
